ktop_kernel_sequencer: RTL and testbench
========================================

Name: ktop_kernel_sequencer

Overview:
- Sits directly downstream of the kernel AXI4-Lite control slave.
- Consumes ap_start and the five 64-bit buffer pointers (axi00_ptr0..3 inputs, axi01_ptr0 output), and returns ap_idle and ap_done to the control slave.
- Launches the four read-stream masters and the one write-stream master with latched addresses and a common transfer length, then waits for all five completions.
- Counts run cycles, enforces an optional watchdog, and reports status.

Parameters:
- C_NUM_RD, 4, number of read channels (axi00_ptr0..3).
- C_LEN_WIDTH, 32, width of xfer_len.
- C_XFER_LEN, 32'd4096, bytes per channel per invocation; driven on xfer_len.
- C_TIMEOUT, 0, watchdog limit in RUN cycles; 0 disables the watchdog.

Ports:
- aclk  in  1  kernel clock
- areset  in  1  asynchronous active-high reset
- ap_start  in  1  level from control slave; held high until it sees ap_done
- ap_idle  out  1  high in IDLE
- ap_done  out  1  one-cycle completion pulse
- axi00_ptr0..axi00_ptr3  in  64 each  read buffer base addresses
- axi01_ptr0  in  64  write buffer base address
- rd_start  out  C_NUM_RD  per-channel one-cycle launch pulse
- rd_addr  out  64*C_NUM_RD  latched read addresses; channel i at [64*i+:64]
- rd_done  in  C_NUM_RD  per-channel one-cycle completion pulse
- wr_start  out  1  write-master launch pulse
- wr_addr  out  64  latched write address
- wr_done  in  1  write-master completion pulse
- xfer_len  out  C_LEN_WIDTH  constant C_XFER_LEN
- run_cycles  out  32  RUN-cycle count of the last or current invocation
- timeout_err  out  1  sticky: last invocation ended by the watchdog

Behaviour:
- Interface: one clock (aclk); areset is asynchronous, active-high, and is applied to every register. No synchronous reset path.
- Reset values:
  - state = IDLE, ap_idle = 1, ap_done = 0.
  - rd_start = 0, wr_start = 0, rd_addr = 0, wr_addr = 0.
  - run_cycles = 0, timeout_err = 0, all done flags cleared.
- IDLE:
  - ap_idle = 1.
  - When ap_start = 1: latch all five pointers into rd_addr/wr_addr, clear done flags, clear run_cycles and timeout_err, go to LAUNCH.
  - Pointer changes while not in IDLE are ignored.
- LAUNCH (exactly 1 cycle):
  - rd_start = all ones and wr_start = 1 for this single cycle; go to RUN.
  - ap_idle = 0 from LAUNCH until return to IDLE.
- RUN:
  - Sticky rd_flag[i] is set on rd_done[i]; wr_flag is set on wr_done.
  - A done pulse arriving in the same cycle the last outstanding flag would be set counts immediately.
  - Done pulses outside RUN are ignored.
  - run_cycles increments each RUN cycle and saturates at 32'hFFFF_FFFF.
  - Go to DONE when all C_NUM_RD+1 flags, including this cycle's pulses, are set.
  - Watchdog: if C_TIMEOUT != 0 and run_cycles == C_TIMEOUT-1 in a RUN cycle with completion not reached, set timeout_err = 1 and go to DONE. Completion in the same cycle takes priority: timeout_err stays 0.
- DONE (1 cycle):
  - ap_done = 1; go to IDLE.
  - Latency: IDLE-seen ap_start to LAUNCH = 1 cycle. Last done pulse to ap_done = 1 cycle.
- Restart: ap_start is still high during the DONE cycle; the control slave clears it on that same edge, so the sequencer re-examines ap_start only in IDLE.
  - A still-high ap_start in IDLE is treated as a new invocation.
  - run_cycles and timeout_err hold their values until the next launch.
- Reset mid-operation: immediate return to reset values. No ap_done is emitted. Outstanding masters are not tracked; late done pulses after reset are ignored because state is IDLE.
- All outputs are registered except ap_idle and ap_done, which are decoded directly from the state register (glitch-free one-hot or Gray encoding).

Test Plan:
- Reset, then ap_start=1 with ptrs 0x1000, 0x2000, 0x3000, 0x4000, 0x8000 -> rd_start=4'hF and wr_start=1 one cycle later; rd_addr/wr_addr match; ap_idle=0.
- After launch, rd_done pulses at RUN cycles 3, 7, 5, 9 (ch0..3) and wr_done at cycle 12 -> ap_done one cycle after wr_done; run_cycles=12; ap_idle=1 the following cycle.
- rd_done[2] and wr_done both arrive as the last pulses in the same cycle -> single ap_done next cycle, no extra wait.
- C_TIMEOUT=20, rd_done[1] never asserted -> after 20 RUN cycles ap_done pulses, timeout_err=1, run_cycles=20; a subsequent clean run clears timeout_err at launch.
- areset asserted in RUN cycle 4 -> all outputs at reset values asynchronously, no ap_done; a later stray rd_done is ignored and ap_idle stays 1.
- ap_start held high through DONE (control slave late) -> one new launch occurs and the pointers are re-latched; pointer changes during RUN do not alter rd_addr.

Source files
------------

// File: rtl/ktop_kernel_sequencer.sv
// ---------------------------------------------------------------------------
// ktop_kernel_sequencer
//
// Purpose:
//   Glue between the kernel AXI4-Lite control slave and the data movers.
//   When the control slave raises ap_start, the sequencer latches the four
//   read buffer pointers and the write buffer pointer. It then fires a
//   one-cycle launch pulse to the four read-stream masters and to the
//   write-stream master, and waits for every master to report completion.
//   After that it returns ap_done / ap_idle to the control slave.
//   While it waits, it counts RUN cycles and can optionally abort through a
//   watchdog.
//
// Ports:
//   aclk         kernel clock
//   areset       asynchronous active-high reset
//   ap_start     start level from the control slave
//   ap_idle      high while idle (decoded from the state register)
//   ap_done      one-cycle completion pulse (decoded from the state register)
//   axi00_ptr0-3 read buffer base addresses, sampled only in IDLE
//   axi01_ptr0   write buffer base address, sampled only in IDLE
//   rd_start     per-read-channel launch pulse
//   rd_addr      latched read addresses, channel i at [64*i +: 64]
//   rd_done      per-read-channel completion pulse
//   wr_start     write-master launch pulse
//   wr_addr      latched write address
//   wr_done      write-master completion pulse
//   xfer_len     constant transfer length, in bytes, for every channel
//   run_cycles   RUN-cycle count of the last or current invocation
//   timeout_err  set when the last invocation was ended by the watchdog
// ---------------------------------------------------------------------------
module ktop_kernel_sequencer #(
    parameter int unsigned              C_NUM_RD    = 4,
    parameter int unsigned              C_LEN_WIDTH = 32,
    parameter logic [C_LEN_WIDTH-1:0]   C_XFER_LEN  = C_LEN_WIDTH'(4096),
    parameter logic [31:0]              C_TIMEOUT   = 32'd0
) (
    input  logic                        aclk,
    input  logic                        areset,

    input  logic                        ap_start,
    output logic                        ap_idle,
    output logic                        ap_done,

    input  logic [63:0]                 axi00_ptr0,
    input  logic [63:0]                 axi00_ptr1,
    input  logic [63:0]                 axi00_ptr2,
    input  logic [63:0]                 axi00_ptr3,
    input  logic [63:0]                 axi01_ptr0,

    output logic [C_NUM_RD-1:0]         rd_start,
    output logic [64*C_NUM_RD-1:0]      rd_addr,
    input  logic [C_NUM_RD-1:0]         rd_done,

    output logic                        wr_start,
    output logic [63:0]                 wr_addr,
    input  logic                        wr_done,

    output logic [C_LEN_WIDTH-1:0]      xfer_len,
    output logic [31:0]                 run_cycles,
    output logic                        timeout_err
);

    // The state is one-hot. Each of ap_idle and ap_done is then a single
    // flop output, which lets both be driven straight from the state
    // register without decode glitches.
    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_LAUNCH = 4'b0010,
        S_RUN    = 4'b0100,
        S_DONE   = 4'b1000
    } state_t;

    state_t                     r_state;
    logic [C_NUM_RD-1:0]        r_rd_flag;
    logic                       r_wr_flag;
    logic [C_NUM_RD-1:0]        r_rd_start;
    logic                       r_wr_start;
    logic [64*C_NUM_RD-1:0]     r_rd_addr;
    logic [63:0]                r_wr_addr;
    logic [31:0]                r_run_cycles;
    logic                       r_timeout_err;

    logic [63:0]                w_ptr [4];
    logic [C_NUM_RD-1:0]        w_rd_flag_next;
    logic                       w_wr_flag_next;
    logic                       w_all_done;
    logic                       w_watchdog_hit;
    logic [31:0]                w_run_cycles_inc;

    // The read pointers are gathered into an array so that the latch loop
    // can index them by channel number.
    assign w_ptr[0] = axi00_ptr0;
    assign w_ptr[1] = axi00_ptr1;
    assign w_ptr[2] = axi00_ptr2;
    assign w_ptr[3] = axi00_ptr3;

    // Completion is judged on the flags as they will be after this cycle.
    // A pulse that arrives in the same cycle as the last outstanding one
    // therefore finishes the invocation without an extra cycle.
    assign w_rd_flag_next = r_rd_flag | rd_done;
    assign w_wr_flag_next = r_wr_flag | wr_done;
    assign w_all_done     = (&w_rd_flag_next) & w_wr_flag_next;

    // The watchdog fires on the last allowed RUN cycle. At that point the
    // counter still holds the count of the cycles before this one.
    // A limit of zero switches the watchdog off.
    assign w_watchdog_hit = (C_TIMEOUT != 32'd0) &&
                            (r_run_cycles == (C_TIMEOUT - 32'd1));

    // The counter saturates, so it never wraps back to a small value.
    assign w_run_cycles_inc = (r_run_cycles == 32'hFFFF_FFFF) ?
                              r_run_cycles : (r_run_cycles + 32'd1);

    // Main sequencer. Launch pulses are registered: they are raised on the
    // edge that enters LAUNCH and dropped on the edge that leaves it.
    // Pointers are sampled only on the IDLE->LAUNCH edge, so pointer changes
    // made by the host mid-invocation have no effect. Done pulses update the
    // flags only while in RUN, so stray pulses in any other state are
    // dropped.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state       <= S_IDLE;
            r_rd_flag     <= '0;
            r_wr_flag     <= 1'b0;
            r_rd_start    <= '0;
            r_wr_start    <= 1'b0;
            r_rd_addr     <= '0;
            r_wr_addr     <= '0;
            r_run_cycles  <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_rd_start <= '0;
            r_wr_start <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        for (int i = 0; i < C_NUM_RD; i++) begin
                            r_rd_addr[64*i +: 64] <= w_ptr[i];
                        end
                        r_wr_addr     <= axi01_ptr0;
                        r_rd_flag     <= '0;
                        r_wr_flag     <= 1'b0;
                        r_run_cycles  <= '0;
                        r_timeout_err <= 1'b0;
                        r_rd_start    <= '1;
                        r_wr_start    <= 1'b1;
                        r_state       <= S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    r_state <= S_RUN;
                end

                S_RUN: begin
                    r_rd_flag    <= w_rd_flag_next;
                    r_wr_flag    <= w_wr_flag_next;
                    r_run_cycles <= w_run_cycles_inc;
                    if (w_all_done) begin
                        r_state <= S_DONE;
                    end else if (w_watchdog_hit) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs come straight from the one-hot state bits.
    // Everything else is a register, or for xfer_len a constant tie-off.
    assign ap_idle     = r_state[0];
    assign ap_done     = r_state[3];
    assign rd_start    = r_rd_start;
    assign wr_start    = r_wr_start;
    assign rd_addr     = r_rd_addr;
    assign wr_addr     = r_wr_addr;
    assign xfer_len    = C_XFER_LEN;
    assign run_cycles  = r_run_cycles;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ktop_kernel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ktop_kernel_sequencer
//
// Directed bench for ktop_kernel_sequencer, built with a 20-cycle watchdog.
// Every launch pushes the expected outcome of that invocation (run_cycles,
// timeout_err and the latched addresses) onto a queue. The entry is popped
// and compared when ap_done appears. Inputs are driven, and outputs sampled,
// on the falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ktop_kernel_sequencer;

    logic           aclk;
    logic           areset;
    logic           ap_start;
    logic           ap_idle;
    logic           ap_done;
    logic [63:0]    axi00_ptr0, axi00_ptr1, axi00_ptr2, axi00_ptr3, axi01_ptr0;
    logic [3:0]     rd_start;
    logic [255:0]   rd_addr;
    logic [3:0]     rd_done;
    logic           wr_start;
    logic [63:0]    wr_addr;
    logic           wr_done;
    logic [31:0]    xfer_len;
    logic [31:0]    run_cycles;
    logic           timeout_err;

    typedef struct {
        logic [31:0]    rc;
        logic           to;
        logic [255:0]   rdAddr;
        logic [63:0]    wrAddr;
    } expT;

    expT sb[$];

    int nAsserts = 0;
    int nFails   = 0;

    ktop_kernel_sequencer #(
        .C_NUM_RD    (4),
        .C_LEN_WIDTH (32),
        .C_XFER_LEN  (32'd4096),
        .C_TIMEOUT   (32'd20)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .ap_start    (ap_start),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .axi00_ptr0  (axi00_ptr0),
        .axi00_ptr1  (axi00_ptr1),
        .axi00_ptr2  (axi00_ptr2),
        .axi00_ptr3  (axi00_ptr3),
        .axi01_ptr0  (axi01_ptr0),
        .rd_start    (rd_start),
        .rd_addr     (rd_addr),
        .rd_done     (rd_done),
        .wr_start    (wr_start),
        .wr_addr     (wr_addr),
        .wr_done     (wr_done),
        .xfer_len    (xfer_len),
        .run_cycles  (run_cycles),
        .timeout_err (timeout_err)
    );

    // 10 ns kernel clock
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // One rising edge, then settle on the following falling edge
    task automatic stepCycle();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    // Single comparison point: counts it and reports any miss
    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present pointers and ap_start in IDLE, record the expected outcome,
    // then check the launch cycle
    task automatic applyStimulus(input logic [63:0] p0, input logic [63:0] p1,
                                 input logic [63:0] p2, input logic [63:0] p3,
                                 input logic [63:0] pw, input int expRc, input logic expTo);
        expT e;
        axi00_ptr0 = p0;
        axi00_ptr1 = p1;
        axi00_ptr2 = p2;
        axi00_ptr3 = p3;
        axi01_ptr0 = pw;
        ap_start   = 1'b1;
        e.rc     = 32'(expRc);
        e.to     = expTo;
        e.rdAddr = {p3, p2, p1, p0};
        e.wrAddr = pw;
        sb.push_back(e);
        stepCycle();
        checkOutput("launchRdStart", 256'(rd_start), 256'(4'hF));
        checkOutput("launchWrStart", 256'(wr_start), 256'(1'b1));
        checkOutput("launchRdAddr", rd_addr, {p3, p2, p1, p0});
        checkOutput("launchWrAddr", 256'(wr_addr), 256'(pw));
        checkOutput("launchIdleLow", 256'(ap_idle), 256'(1'b0));
        checkOutput("launchNoDone", 256'(ap_done), 256'(1'b0));
        checkOutput("launchRunCycles", 256'(run_cycles), 256'(0));
        checkOutput("launchTimeoutClr", 256'(timeout_err), 256'(1'b0));
    endtask

    // Fire done pulses at the given RUN cycles (0 means never). Wait a
    // bounded number of cycles for ap_done, then check the scoreboard entry.
    task automatic runPhase(input int c0, input int c1, input int c2, input int c3,
                            input int cw, input int expDone, input bit dropStart);
        bit seen;
        expT e;
        seen = 1'b0;
        stepCycle();
        checkOutput("launchPulseGone", 256'({rd_start, wr_start}), 256'(5'b0));
        for (int k = 1; k <= 40 && !seen; k++) begin
            rd_done = {c3 == k, c2 == k, c1 == k, c0 == k};
            wr_done = (cw == k);
            stepCycle();
            rd_done = 4'b0;
            wr_done = 1'b0;
            if (ap_done) begin
                seen = 1'b1;
                checkOutput("doneLatency", 256'(k), 256'(expDone));
                checkOutput("sbNonEmpty", 256'(sb.size() != 0), 256'(1'b1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checkOutput("doneRunCycles", 256'(run_cycles), 256'(e.rc));
                    checkOutput("doneTimeoutErr", 256'(timeout_err), 256'(e.to));
                    checkOutput("doneRdAddr", rd_addr, e.rdAddr);
                    checkOutput("doneWrAddr", 256'(wr_addr), 256'(e.wrAddr));
                end
                checkOutput("doneIdleLow", 256'(ap_idle), 256'(1'b0));
            end else begin
                checkOutput("runIdleLow", 256'(ap_idle), 256'(1'b0));
            end
        end
        checkOutput("doneSeen", 256'(seen), 256'(1'b1));
        if (dropStart) ap_start = 1'b0;
        stepCycle();
        checkOutput("postDoneIdle", 256'(ap_idle), 256'(1'b1));
        checkOutput("postDoneSingle", 256'(ap_done), 256'(1'b0));
    endtask

    initial begin
        areset     = 1'b1;
        ap_start   = 1'b0;
        rd_done    = 4'b0;
        wr_done    = 1'b0;
        axi00_ptr0 = 64'h0;
        axi00_ptr1 = 64'h0;
        axi00_ptr2 = 64'h0;
        axi00_ptr3 = 64'h0;
        axi01_ptr0 = 64'h0;

        // Reset state
        @(negedge aclk);
        @(negedge aclk);
        checkOutput("rstIdle", 256'(ap_idle), 256'(1'b1));
        checkOutput("rstDone", 256'(ap_done), 256'(1'b0));
        checkOutput("rstStarts", 256'({rd_start, wr_start}), 256'(5'b0));
        checkOutput("rstRdAddr", rd_addr, 256'(0));
        checkOutput("rstWrAddr", 256'(wr_addr), 256'(0));
        checkOutput("rstRunCycles", 256'(run_cycles), 256'(0));
        checkOutput("rstTimeoutErr", 256'(timeout_err), 256'(1'b0));
        checkOutput("xferLen", 256'(xfer_len), 256'(32'd4096));
        areset = 1'b0;
        stepCycle();
        checkOutput("idleNoLaunch", 256'({rd_start, wr_start}), 256'(5'b0));

        // Basic invocation: staggered read completions, write finishes last
        $display("[TB] basic invocation");
        applyStimulus(64'h1000, 64'h2000, 64'h3000, 64'h4000, 64'h8000, 12, 1'b0);
        runPhase(3, 7, 5, 9, 12, 12, 1'b1);

        // The last read and the write both complete in the same cycle
        $display("[TB] simultaneous final pulses");
        applyStimulus(64'h11000, 64'h12000, 64'h13000, 64'h14000, 64'h18000, 8, 1'b0);
        runPhase(2, 3, 8, 5, 8, 8, 1'b1);

        // Watchdog: channel 1 never completes
        $display("[TB] watchdog expiry");
        applyStimulus(64'hA000, 64'hB000, 64'hC000, 64'hD000, 64'hE000, 20, 1'b1);
        runPhase(1, 0, 2, 3, 4, 20, 1'b1);

        // A clean run after the timeout clears timeout_err at launch.
        // Every pulse arrives in the first RUN cycle.
        $display("[TB] clean run after timeout");
        applyStimulus(64'h100, 64'h200, 64'h300, 64'h400, 64'h500, 1, 1'b0);
        runPhase(1, 1, 1, 1, 1, 1, 1'b1);

        // Asynchronous reset in RUN cycle 4
        $display("[TB] reset mid-run");
        applyStimulus(64'h5100, 64'h5200, 64'h5300, 64'h5400, 64'h5800, 0, 1'b0);
        stepCycle();
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("preRstRunCycles", 256'(run_cycles), 256'(3));
        #2;
        areset   = 1'b1;
        ap_start = 1'b0;
        #1;
        checkOutput("asyncRstIdle", 256'(ap_idle), 256'(1'b1));
        checkOutput("asyncRstDone", 256'(ap_done), 256'(1'b0));
        checkOutput("asyncRstRdAddr", rd_addr, 256'(0));
        checkOutput("asyncRstWrAddr", 256'(wr_addr), 256'(0));
        checkOutput("asyncRstRunCycles", 256'(run_cycles), 256'(0));
        // The aborted invocation never completes, so drop its expectation
        if (sb.size() != 0) void'(sb.pop_front());
        @(negedge aclk);
        areset = 1'b0;
        rd_done = 4'b0010;
        wr_done = 1'b1;
        stepCycle();
        rd_done = 4'b0;
        wr_done = 1'b0;
        checkOutput("strayIdle", 256'(ap_idle), 256'(1'b1));
        checkOutput("strayNoDone", 256'(ap_done), 256'(1'b0));
        checkOutput("strayNoLaunch", 256'({rd_start, wr_start}), 256'(5'b0));
        stepCycle();
        checkOutput("strayIdleLater", 256'(ap_idle), 256'(1'b1));
        checkOutput("strayRunCycles", 256'(run_cycles), 256'(0));

        // ap_start held through DONE gives one relaunch with re-latched
        // pointers. Pointer changes made during RUN are ignored.
        $display("[TB] held ap_start and pointer changes");
        applyStimulus(64'h7100, 64'h7200, 64'h7300, 64'h7400, 64'h7800, 3, 1'b0);
        axi00_ptr0 = 64'h9100;
        axi00_ptr1 = 64'h9200;
        axi00_ptr2 = 64'h9300;
        axi00_ptr3 = 64'h9400;
        axi01_ptr0 = 64'h9800;
        runPhase(2, 2, 2, 2, 3, 3, 1'b0);
        applyStimulus(64'h9100, 64'h9200, 64'h9300, 64'h9400, 64'h9800, 5, 1'b0);
        runPhase(4, 3, 2, 1, 5, 5, 1'b1);
        stepCycle();
        checkOutput("noExtraLaunch", 256'({rd_start, wr_start}), 256'(5'b0));
        checkOutput("finalIdle", 256'(ap_idle), 256'(1'b1));
        checkOutput("sbDrained", 256'(sb.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
